// File: rtl/wave_reader_if.sv
// wave_reader_if: control, RAM read port and playback outputs of the wave reader.
interface wave_reader_if #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              enable;
  logic [ACC_W-1:0]  freq_word;
  logic              freq_load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              wrap;
  logic              busy;
  modport master (
    output enable, freq_word, freq_load, data,
    input  address, sample, sample_valid, wrap, busy
  );
  modport slave (
    input  enable, freq_word, freq_load, data,
    output address, sample, sample_valid, wrap, busy
  );
endinterface

// File: rtl/wave_reader.sv
// wave_reader: phase-accumulator waveform RAM reader with graceful stop at the next carry.
module wave_reader #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic        clk,
  input logic        rst,
  wave_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t            state_q, state_d;
  logic [ACC_W-1:0]  phase_q, phase_d, freq_q;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic [DATA_W-1:0] sample_q;
  logic              valid_q, wrap_q, busy;
  assign sum   = {1'b0, phase_q} + {1'b0, freq_q};
  assign carry = sum[ACC_W];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  // STOPPING finishes on the carry edge, or at once when the stride is zero
  always_comb begin
    state_d = state_q == IDLE ? (bus.enable ? RUN : IDLE)
            : bus.enable      ? RUN
            : state_q == RUN  ? STOPPING
            : (carry || freq_q == '0) ? IDLE : STOPPING;
    phase_d = (state_q == IDLE || state_d == IDLE) ? '0 : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= '0;
      freq_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (bus.freq_load) freq_q <= bus.freq_word;
      wrap_q  <= state_q != IDLE && carry;
      valid_q <= state_d != IDLE;
      if (state_d != IDLE) sample_q <= bus.data;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
  end
  assign bus.address      = phase_q[ACC_W-1 -: ADDR_W];
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.wrap         = wrap_q;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_wave_reader.sv
// tb_wave_reader: directed playback scenarios checked every cycle against a behavioural model.
module tb_wave_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ram [256];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int m_state = 0, m_phase = 0, m_freq = 0, m_sample = 0, m_valid = 0, m_wrap = 0;
  wave_reader_if #(.ACC_W(16), .ADDR_W(8), .DATA_W(8)) bus ();
  wave_reader #(.ACC_W(16), .ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.data = ram[bus.address];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // model states: 0 idle, 1 run, 2 stopping; phase kept as a plain integer
  always @(posedge clk or negedge rst) begin
    int ns;
    bit carry;
    if (!rst) begin
      m_state = 0; m_phase = 0; m_freq = 0; m_sample = 0; m_valid = 0; m_wrap = 0;
    end else begin
      carry = m_state != 0 && m_phase + m_freq >= 65536;
      if (m_state == 0)      ns = bus.enable ? 1 : 0;
      else if (bus.enable)   ns = 1;
      else if (m_state == 1) ns = 2;
      else                   ns = (carry || m_freq == 0) ? 0 : 2;
      m_wrap = carry;
      if (ns != 0) begin
        m_sample = ram[m_phase / 256];
        m_valid  = 1;
      end else m_valid = 0;
      m_phase = (m_state == 0 || ns == 0) ? 0 : (m_phase + m_freq) % 65536;
      if (bus.freq_load) m_freq = bus.freq_word;
      m_state = ns;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("address", bus.address, m_phase / 256);
      chk("sample", bus.sample, m_sample);
      chk("sample_valid", bus.sample_valid, m_valid);
      chk("wrap", bus.wrap, m_wrap);
      chk("busy", bus.busy, m_state != 0 ? 1 : 0);
    end
  end
  task automatic wait_addr(input int a);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.address == 8'(a)) return;
    end
    chk("wait_addr_timeout", bus.address, a);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    chk("wait_idle_timeout", bus.busy, 0);
  endtask
  task automatic start(input logic [15:0] fw);
    bus.freq_word = fw;
    bus.freq_load = 1'b1;
    bus.enable    = 1'b1;
    @(negedge clk);
    bus.freq_load = 1'b0;
  endtask
  initial begin
    int wraps, cnt;
    for (int k = 0; k < 256; k++) ram[k] = 8'(k);
    bus.enable = 1'b0; bus.freq_word = '0; bus.freq_load = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_address", bus.address, 0);
    chk("rst_sample", bus.sample, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    start(16'h0100);
    wraps = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.wrap) begin
        wraps++;
        chk("wrap_at_zero", bus.address, 0);
      end
    end
    chk("wrap_count", wraps, 1);
    wait_addr(8'h40);
    bus.enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else break;
    end
    chk("stop_cycles", cnt, 191);
    chk("stop_addr", bus.address, 0);
    chk("stop_valid", bus.sample_valid, 0);
    bus.enable = 1'b1;
    wait_addr(8'h40);
    bus.enable = 1'b0;
    wait_addr(8'h80);
    bus.enable = 1'b1;
    wait_addr(8'h90);
    chk("resume_busy", bus.busy, 1);
    bus.enable = 1'b0;
    wait_idle();
    start(16'h0200);
    wait_addr(8'h02);
    @(negedge clk);
    chk("sample_trail", bus.sample, 2);
    bus.enable = 1'b0;
    wait_idle();
    start(16'h8000);
    wait_addr(8'h80);
    bus.freq_word = 16'h4000;
    bus.freq_load = 1'b1;
    @(negedge clk);
    bus.freq_load = 1'b0;
    chk("load_carry_addr", bus.address, 8'h00);
    chk("load_carry_wrap", bus.wrap, 1);
    @(negedge clk);
    chk("new_stride_addr", bus.address, 8'h40);
    @(negedge clk);
    chk("new_stride_addr2", bus.address, 8'h80);
    bus.enable = 1'b0;
    wait_idle();
    start(16'h0100);
    wait_addr(8'h37);
    #2 rst = 1'b0;
    #1;
    chk("arst_address", bus.address, 0);
    chk("arst_sample", bus.sample, 0);
    chk("arst_valid", bus.sample_valid, 0);
    chk("arst_wrap", bus.wrap, 0);
    chk("arst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("zero_freq_addr", bus.address, 0);
    chk("zero_freq_valid", bus.sample_valid, 1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("zero_freq_stopping", bus.busy, 1);
    @(negedge clk);
    chk("zero_freq_idle", bus.busy, 0);
    chk("zero_freq_wrap", bus.wrap, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
